// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver for the byte holding register.
// rx is double-flopped into rx_s. Each frame is aligned on the middle of the
// start bit, so every later full-bit count lands mid-bit. A low stop bit
// raises frame_err and parks the FSM in BREAK until the line returns high.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID     = CW'((CLKS_PER_BIT - 1) / 2);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic          rx_p0;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] counter;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  // Frame FSM, bit counter, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      counter    <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (counter == MID) begin
            counter <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end
        DATA: begin
          if (counter == BIT_END) begin
            counter        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end
        STOP: begin
          if (counter == BIT_END) begin
            counter <= '0;
            if (rx_s) begin
              data_out   <= shift;
              data_valid <= 1'b1;
              frame_err  <= 1'b0;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end
        BRK: begin
          // A held-low line must go high before another frame can begin.
          counter <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte at CLKS_PER_BIT=8. Frames are generated bit by
// bit; expectations come from a frame-level model (last good byte, error flag).
module tb_uart_rx_byte;

  localparam int CPB = 8;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int tests;
  int fails;
  int cyc;

  // Monitor records (value, cycle) of every data_valid cycle and busy cycles.
  logic [7:0] obs_val[$];
  int         obs_cyc[$];
  int         busy_cnt;

  // Frame-level reference state.
  logic [7:0] m_last;
  logic       m_err;
  int         fall_cyc;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .data_out(data_out), .data_valid(data_valid),
    .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      obs_val.push_back(data_out);
      obs_cyc.push_back(cyc);
    end
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
    fall_cyc = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop, stop_len);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    m_last = 8'h00;
    m_err = 1'b0;
    drive(1'b1, 4);
  endtask

  task automatic test_good_frame;
    int n0;
    n0 = obs_val.size();
    send_frame(8'hA5, 1'b1, CPB);
    drive(1'b1, 6);
    m_last = 8'hA5;
    m_err = 1'b0;
    tests++; if (obs_val.size() - n0 !== 1) begin fails++; $display("FAIL good_pulse_count got=%0d exp=1", obs_val.size() - n0); end
    if (obs_val.size() > n0) begin
      tests++; if (obs_val[n0] !== 8'hA5) begin fails++; $display("FAIL good_pulse_value got=%h exp=a5", obs_val[n0]); end
      tests++;
      if (obs_cyc[n0] - fall_cyc < 76 || obs_cyc[n0] - fall_cyc > 80) begin
        fails++; $display("FAIL good_latency got=%0d exp=76..80", obs_cyc[n0] - fall_cyc);
      end
    end
    tests++; if (data_out !== m_last) begin fails++; $display("FAIL good_data_out got=%h exp=%h", data_out, m_last); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL good_frame_err got=%b exp=0", frame_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL good_busy got=%b exp=0", busy); end
  endtask

  task automatic test_glitch;
    int n0, b0;
    n0 = obs_val.size();
    b0 = busy_cnt;
    drive(1'b0, 2);
    drive(1'b1, 20);
    tests++; if (busy_cnt == b0) begin fails++; $display("FAIL glitch_busy_pulse got=0 cycles exp=>0"); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    tests++; if (obs_val.size() != n0) begin fails++; $display("FAIL glitch_no_pulse got=%0d exp=0", obs_val.size() - n0); end
    tests++; if (data_out !== m_last) begin fails++; $display("FAIL glitch_data_out got=%h exp=%h", data_out, m_last); end
  endtask

  task automatic test_frame_err;
    int n0;
    n0 = obs_val.size();
    send_frame(8'h3C, 1'b0, 20);
    m_err = 1'b1;
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
    tests++; if (obs_val.size() != n0) begin fails++; $display("FAIL ferr_no_pulse got=%0d exp=0", obs_val.size() - n0); end
    tests++; if (data_out !== m_last) begin fails++; $display("FAIL ferr_data_out got=%h exp=%h", data_out, m_last); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ferr_busy_held got=%b exp=1", busy); end
    drive(1'b1, 5);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL ferr_flag_hold got=%b exp=1", frame_err); end
    send_frame(8'h00, 1'b1, CPB);
    drive(1'b1, 4);
    m_last = 8'h00;
    m_err = 1'b0;
    tests++; if (obs_val.size() - n0 !== 1) begin fails++; $display("FAIL ferr_recover_count got=%0d exp=1", obs_val.size() - n0); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL ferr_recover_data got=%h exp=00", data_out); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL ferr_recover_flag got=%b exp=0", frame_err); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int n0;
    b = 8'h5A;
    n0 = obs_val.size();
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(b[i], CPB);
    drive(b[4], 4);
    reset = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    m_last = 8'h00;
    m_err = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL rstmid_data_out got=%h exp=00", data_out); end
    drive(1'b1, 90);
    tests++; if (obs_val.size() != n0) begin fails++; $display("FAIL rstmid_no_pulse got=%0d exp=0", obs_val.size() - n0); end
    send_frame(8'hFF, 1'b1, CPB);
    drive(1'b1, 4);
    m_last = 8'hFF;
    tests++; if (data_out !== 8'hFF) begin fails++; $display("FAIL rstmid_after got=%h exp=ff", data_out); end
    tests++; if (obs_val.size() - n0 !== 1) begin fails++; $display("FAIL rstmid_after_count got=%0d exp=1", obs_val.size() - n0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    int n0;
    exp_q = {8'h01, 8'h80};
    for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    n0 = obs_val.size();
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, CPB);
    drive(1'b1, 4);
    m_last = exp_q[exp_q.size() - 1];
    m_err = 1'b0;
    tests++; if (obs_val.size() - n0 !== exp_q.size()) begin fails++; $display("FAIL b2b_count got=%0d exp=%0d", obs_val.size() - n0, exp_q.size()); end
    foreach (exp_q[i]) begin
      if (n0 + i < obs_val.size()) begin
        tests++; if (obs_val[n0 + i] !== exp_q[i]) begin fails++; $display("FAIL b2b_value%0d got=%h exp=%h", i, obs_val[n0 + i], exp_q[i]); end
      end
    end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL b2b_frame_err got=%b exp=0", frame_err); end
    tests++; if (data_out !== m_last) begin fails++; $display("FAIL b2b_data_out got=%h exp=%h", data_out, m_last); end
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic       stop;
    int         n0;
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      n0 = obs_val.size();
      send_frame(b, stop, CPB);
      if (stop) m_last = b;
      m_err = ~stop;
      tests++; if (obs_val.size() - n0 !== (stop ? 1 : 0)) begin fails++; $display("FAIL rand%0d_count got=%0d exp=%0d", k, obs_val.size() - n0, stop ? 1 : 0); end
      if (stop && obs_val.size() > n0) begin
        tests++; if (obs_val[n0] !== b) begin fails++; $display("FAIL rand%0d_value got=%h exp=%h", k, obs_val[n0], b); end
      end
      tests++; if (data_out !== m_last) begin fails++; $display("FAIL rand%0d_data_out got=%h exp=%h", k, data_out, m_last); end
      tests++; if (frame_err !== m_err) begin fails++; $display("FAIL rand%0d_frame_err got=%b exp=%b", k, frame_err, m_err); end
      drive(1'b1, stop ? $urandom_range(0, 5) : $urandom_range(4, 9));
    end
    drive(1'b1, 4);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rand_busy_end got=%b exp=0", busy); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    busy_cnt = 0;
    reset = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
